// File: rtl/edge_arb_pkg.sv
// Shared types for the edge-event arbiter: per-channel edge mode and arbiter FSM state.
package edge_arb_pkg;
   typedef enum logic [1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_t;
   typedef enum logic {ST_IDLE, ST_OFFER} edge_arb_state_t;
endpackage

// File: rtl/edge_event_channel.sv
// One watched input: edge detect, mode qualify, saturating pending count, sticky overflow.
module edge_event_channel
   import edge_arb_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       a,
   input  logic [1:0] mode,
   input  logic       dec,
   input  logic       ovf_clr,
   output logic       nonzero,
   output logic       ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             a_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rise, fall, hit, sat;

   assign rise = a & ~a_q;
   assign fall = ~a & a_q;

   // Qualify the edge seen this clock against the mode presented on the same clock
   always_comb begin
      hit = 1'b0;
      case (edge_mode_t'(mode))
         EDGE_RISE: hit = rise;
         EDGE_FALL: hit = fall;
         EDGE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
   end

   // Increment and grant decrement cancel; a full counter drops the edge and flags overflow
   always_comb begin
      sat   = hit && !dec && (cnt_q == CNT_MAX);
      cnt_d = cnt_q;
      if (hit && !dec && !sat) cnt_d = cnt_q + 1'b1;
      else if (!hit && dec)    cnt_d = cnt_q - 1'b1;
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (sat)     ovf_d = 1'b1;
   end

   // Input history, count and overflow state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_q   <= 1'b0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign nonzero = (cnt_q != '0);
   assign ovf     = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel queued edges served round-robin
// through one valid/ready event port.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [N_CH-1:0]         a,
   input  logic [2*N_CH-1:0]       mode,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(N_CH)-1:0] evt_ch,
   output logic [N_CH-1:0]         ovf,
   input  logic [N_CH-1:0]         ovf_clr,
   output logic                    pending
);

   localparam int CH_W = $clog2(N_CH);

   edge_arb_state_t state_q;
   logic [CH_W-1:0] rr_q, evt_ch_q, sel, idx, rr_d;
   logic            evt_valid_q, any, load;
   logic [N_CH-1:0] nonzero, dec;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_event_channel #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .resetn  (resetn),
         .a       (a[i]),
         .mode    (mode[2*i +: 2]),
         .dec     (dec[i]),
         .ovf_clr (ovf_clr[i]),
         .nonzero (nonzero[i]),
         .ovf     (ovf[i])
      );
   end

   assign any = |nonzero;
   // A new event loads from idle, or back-to-back on the handshake of the current one
   assign load = any && ((state_q == ST_IDLE) || evt_ready);

   // Round-robin pick: first non-empty channel at or after the pointer, with wrap
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = CH_W'((int'(rr_q) + k) % N_CH);
         if (nonzero[idx]) sel = idx;
      end
      rr_d = (sel == CH_W'(N_CH - 1)) ? '0 : sel + 1'b1;
   end

   // Grant decrement goes to the selected channel only
   always_comb begin
      dec = '0;
      for (int i = 0; i < N_CH; i++) dec[i] = load && (sel == CH_W'(i));
   end

   // Offer FSM; evt_ch only changes on a load so it stays stable while offered
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         rr_q        <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  evt_ch_q    <= sel;
                  evt_valid_q <= 1'b1;
                  rr_q        <= rr_d;
                  state_q     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (load) begin
                  evt_ch_q <= sel;
                  rr_q     <= rr_d;
               end else if (evt_ready) begin
                  evt_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               evt_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign pending   = any;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed plus random checks of edge_event_arbiter against a per-cycle behavioural model.
module tb_edge_event_arbiter;
   localparam int N_CH  = 4;
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              resetn;
   logic [N_CH-1:0]   a;
   logic [2*N_CH-1:0] mode;
   logic              evt_valid, evt_ready, pending;
   logic [1:0]        evt_ch;
   logic [N_CH-1:0]   ovf, ovf_clr;

   edge_event_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .a(a), .mode(mode), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_ch(evt_ch), .ovf(ovf), .ovf_clr(ovf_clr), .pending(pending)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int dut_ev[$];

   // Behavioural model: pending counts, sticky flags, current offer, rr pointer, previous input
   int cnt[N_CH];
   bit movf[N_CH];
   bit prev_a[N_CH];
   bit mvalid;
   int mch, rr;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin cnt[i] = 0; movf[i] = 0; prev_a[i] = 0; end
      mvalid = 0; mch = 0; rr = 0;
   endtask

   function automatic bit qualifies(int i);
      bit r, f;
      r = a[i] && !prev_a[i];
      f = !a[i] && prev_a[i];
      case (mode[2*i +: 2])
         2'd1: return r;
         2'd2: return f;
         2'd3: return r | f;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      bit hs, e;
      int pick, j;
      hs = mvalid && evt_ready;
      pick = -1;
      if (!mvalid || hs)
         for (int k = 0; k < N_CH; k++) begin
            j = (rr + k) % N_CH;
            if (pick < 0 && cnt[j] > 0) pick = j;
         end
      if (pick >= 0) begin mvalid = 1; mch = pick; rr = (pick + 1) % N_CH; end
      else if (hs) mvalid = 0;
      for (int i = 0; i < N_CH; i++) begin
         e = qualifies(i);
         if (ovf_clr[i]) movf[i] = 0;
         if (pick == i) cnt[i]--;
         if (e) begin
            if (cnt[i] == MAXC) movf[i] = 1;
            else cnt[i]++;
         end
         prev_a[i] = a[i];
      end
   endtask

   task automatic model_cmp(string tag);
      logic [N_CH-1:0] eo;
      bit ep;
      ep = 0;
      for (int i = 0; i < N_CH; i++) begin eo[i] = movf[i]; if (cnt[i] > 0) ep = 1; end
      chk({tag, "_valid"}, evt_valid, mvalid);
      chk({tag, "_ch"}, evt_ch, mch);
      chk({tag, "_ovf"}, ovf, eo);
      chk({tag, "_pend"}, pending, ep);
   endtask

   // One clock: record DUT handshake, advance model on the edge, compare on the falling edge
   task automatic cycle(string tag);
      if (resetn && evt_valid && evt_ready) dut_ev.push_back(int'(evt_ch));
      @(posedge clk);
      if (resetn) model_step(); else model_reset();
      @(negedge clk);
      model_cmp(tag);
   endtask

   task automatic expect_ev(string tag, int n, int e0 = 0, int e1 = 0, int e2 = 0, int e3 = 0);
      int e[4];
      e = '{e0, e1, e2, e3};
      chk({tag, "_nev"}, dut_ev.size(), n);
      for (int i = 0; i < n && i < dut_ev.size(); i++) chk({tag, "_ev"}, dut_ev[i], e[i]);
      dut_ev.delete();
   endtask

   task automatic set_mode(int i, logic [1:0] m);
      mode[2*i +: 2] = m;
   endtask

   task automatic do_reset(int n);
      resetn = 1'b0;
      model_reset();
      for (int i = 0; i < n; i++) cycle("rst");
      resetn = 1'b1;
   endtask

   initial begin
      int vcnt;
      a = '0; mode = '0; evt_ready = 1'b0; ovf_clr = '0; resetn = 1'b0;
      model_reset();
      @(negedge clk);

      // 1: reset, then a high input at release is a rising edge
      do_reset(4);
      chk("t1_rst_valid", evt_valid, 0);
      chk("t1_rst_ovf", ovf, 0);
      chk("t1_rst_pend", pending, 0);
      resetn = 1'b1; a = 4'b1000; set_mode(3, 2'd1); evt_ready = 1'b1;
      cycle("t1"); cycle("t1");
      chk("t1_ch", evt_ch, 3);
      chk("t1_v", evt_valid, 1);
      cycle("t1"); cycle("t1");
      expect_ev("t1", 1, 3);

      // 2: single rise on ch0, one-clock offer; fall ignored
      set_mode(3, 2'd0); set_mode(0, 2'd1); a = 4'b0001;
      cycle("t2");
      chk("t2_lat0", evt_valid, 0);
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin cycle("t2"); vcnt += int'(evt_valid); end
      chk("t2_vcnt", vcnt, 1);
      expect_ev("t2", 1, 0);
      a = 4'b0000;
      for (int i = 0; i < 4; i++) cycle("t2f");
      expect_ev("t2f", 0);

      // 3: both edges on ch2 with consumer stalled
      set_mode(0, 2'd0); set_mode(2, 2'd3); evt_ready = 1'b0;
      a = 4'b0100; cycle("t3");
      a = 4'b0000; cycle("t3");
      a = 4'b0100; cycle("t3");
      cycle("t3"); cycle("t3");
      chk("t3_held_v", evt_valid, 1);
      chk("t3_held_ch", evt_ch, 2);
      chk("t3_pend", pending, 1);
      evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle("t3r");
      expect_ev("t3", 3, 2, 2, 2);
      chk("t3_end_v", evt_valid, 0);

      // 4: simultaneous rises, round-robin order from a fresh pointer
      set_mode(2, 2'd0); a = 4'b0000;
      do_reset(2);
      for (int i = 0; i < N_CH; i++) set_mode(i, 2'd1);
      a = 4'b1111;
      for (int i = 0; i < 7; i++) cycle("t4");
      expect_ev("t4a", 4, 0, 1, 2, 3);
      a = 4'b0000; cycle("t4"); cycle("t4");
      a = 4'b1010;
      for (int i = 0; i < 5; i++) cycle("t4");
      expect_ev("t4b", 2, 1, 3);

      // 5: overflow on ch1 while stalled, drain, clear
      mode = '0; a = 4'b0000; evt_ready = 1'b0;
      cycle("t5"); cycle("t5");
      set_mode(1, 2'd1);
      for (int r = 0; r < 5; r++) begin
         a = 4'b0010; cycle("t5");
         a = 4'b0000; cycle("t5");
      end
      chk("t5_ovf_set", ovf, 4'b0010);
      evt_ready = 1'b1;
      for (int i = 0; i < 7; i++) cycle("t5d");
      expect_ev("t5", 1 + MAXC, 1, 1, 1, 1);
      chk("t5_ovf_sticky", ovf, 4'b0010);
      ovf_clr = 4'b0010; cycle("t5c");
      ovf_clr = 4'b0000; cycle("t5c");
      chk("t5_ovf_clr", ovf, 4'b0000);

      // 6: asynchronous reset while offering
      set_mode(1, 2'd0); set_mode(0, 2'd1); evt_ready = 1'b0;
      a = 4'b0001;
      for (int i = 0; i < 3; i++) cycle("t6");
      chk("t6_offer", evt_valid, 1);
      a = 4'b0000;
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_v", evt_valid, 0);
      chk("t6_async_pend", pending, 0);
      model_reset();
      @(negedge clk);
      cycle("t6r");
      resetn = 1'b1; evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle("t6q");
      expect_ev("t6", 0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         a = N_CH'($urandom);
         if ($urandom_range(0, 3) == 0) mode = (2*N_CH)'($urandom);
         evt_ready = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 80 : 20));
         ovf_clr = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '0;
         cycle("rnd");
      end
      dut_ev.delete();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
